// File: rtl/pcihellocore_pio_out_multi.sv
// Multi-channel Avalon-MM output PIO with atomic bit set/clear per channel.
// Define PCIHELLOCORE_PIO_BLINK_EN to build the per-channel hardware blink mask.
module pcihellocore_pio_out_multi #(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = 32,
  parameter int               ADDR_W      = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_CH*WIDTH-1:0] out_port
);

  localparam int CH_W = ADDR_W - 2;

  localparam logic [1:0] R_DATA  = 2'd0;
  localparam logic [1:0] R_SET   = 2'd1;
  localparam logic [1:0] R_CLR   = 2'd2;
  localparam logic [1:0] R_BMASK = 2'd3;

  if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || WIDTH > 32 ||
      ADDR_W < 3 || ADDR_W < $clog2(NUM_CH) + 2 ||
      BLINK_DIV < 2) begin : g_bad_param
    $error("pcihellocore_pio_out_multi: illegal parameters");
  end

  logic [CH_W-1:0]  ch;
  logic [1:0]       rsel;
  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  assign ch        = address[ADDR_W-1:2];
  assign rsel      = address[1:0];
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  logic [WIDTH-1:0] data_q   [NUM_CH];
  logic [WIDTH-1:0] next_out [NUM_CH];
  logic [WIDTH-1:0] rd_bmask [NUM_CH];
  logic [WIDTH-1:0] rd;

  // Channels outside NUM_CH never match, so their writes fall away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++)
        data_q[c] <= RESET_VALUE;
    end else if (wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch == CH_W'(c)) begin
          unique case (1'b1)
            rsel == R_DATA: data_q[c] <= wd;
            rsel == R_SET:  data_q[c] <= data_q[c] | wd;
            rsel == R_CLR:  data_q[c] <= data_q[c] & ~wd;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PCIHELLOCORE_PIO_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic [WIDTH-1:0] bmask_q [NUM_CH];

  // Free-running; mask writes never disturb the blink timebase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++)
        bmask_q[c] <= '0;
    end else if (wr && rsel == R_BMASK) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch == CH_W'(c))
          bmask_q[c] <= wd;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      next_out[c] = data_q[c] ^ (bmask_q[c] & {WIDTH{phase_q}});
      rd_bmask[c] = bmask_q[c];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      next_out[c] = data_q[c];
      rd_bmask[c] = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++)
        out_port[c*WIDTH +: WIDTH] <= RESET_VALUE;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        out_port[c*WIDTH +: WIDTH] <= next_out[c];
    end
  end

  always_comb begin
    rd = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch == CH_W'(c))
        rd = (rsel == R_BMASK) ? rd_bmask[c] : data_q[c];
    readdata = 32'(rd);
  end

endmodule

// File: tb/tb_pcihellocore_pio_out_multi.sv
// Bench for pcihellocore_pio_out_multi: 3 channels x 8 bits, reset value 0x05.
// Blink expectations follow PCIHELLOCORE_PIO_BLINK_EN when it is defined.
module tb_pcihellocore_pio_out_multi;

  localparam int         NUM_CH = 3;
  localparam int         WIDTH  = 8;
  localparam int         ADDR_W = 4;
  localparam logic [7:0] RV     = 8'h05;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [23:0] out_port;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] sb[$];

  typedef struct {
    logic [3:0]  a;
    logic [31:0] wd;
    logic [23:0] out;
    logic [31:0] rd;
  } vec_t;

  vec_t v[9];

  always #5 clk = ~clk;

  pcihellocore_pio_out_multi #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W),
    .RESET_VALUE(RV), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name,
                          input logic [3:0] a,
                          input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  // Drive one write cycle; returns at the negedge after the write edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic pop_chk(input string name);
    logic [23:0] e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, 32'(out_port), 32'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] prev;
    logic [7:0]  s[20];
    int          f;
    logic        chg, want;

    v[0] = '{4'h4, 32'h0000_00F0, 24'h05F005, 32'hF0};
    v[1] = '{4'h5, 32'h0000_000F, 24'h05FF05, 32'hFF};
    v[2] = '{4'h6, 32'h0000_00C0, 24'h053F05, 32'h3F};
    v[3] = '{4'hC, 32'h0000_00AA, 24'h053F05, 32'h00};
    v[4] = '{4'h0, 32'h0000_1234, 24'h053F34, 32'h34};
    v[5] = '{4'h8, 32'hFFFF_FF81, 24'h813F34, 32'h81};
    v[6] = '{4'h9, 32'h0000_0002, 24'h833F34, 32'h83};
    v[7] = '{4'h2, 32'h0000_00FF, 24'h833F00, 32'h00};
    v[8] = '{4'hE, 32'h0000_00FF, 24'h833F00, 32'h00};

    repeat (3) @(negedge clk);
    check("reset_out_in_reset", 32'(out_port), 32'h050505);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out", 32'(out_port), 32'h050505);
    read_chk("reset_rd_ch0", 4'h0, 32'h05);
    read_chk("reset_rd_ch1", 4'h4, 32'h05);
    read_chk("reset_rd_ch2", 4'h8, 32'h05);
    read_chk("reset_bmask", 4'h3, 32'h00);
    read_chk("reset_rd_ch3", 4'hC, 32'h00);

    prev = 24'h050505;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(v[i].out);
      bus_write(v[i].a, v[i].wd);
      check($sformatf("lat_%0d", i), 32'(out_port), 32'(prev));
      read_chk($sformatf("rd_%0d", i), v[i].a, v[i].rd);
      @(negedge clk);
      pop_chk($sformatf("out_%0d", i));
      prev = v[i].out;
    end

    // Read during the write cycle sees the old value.
    @(negedge clk);
    address = 4'h4; writedata = 32'h55;
    chipselect = 1'b1; write_n = 1'b0;
    sb.push_back(24'h835500);
    #1;
    check("rdw_old", readdata, 32'h3F);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1;
    check("rdw_new", readdata, 32'h55);
    @(negedge clk);
    pop_chk("rdw_out");

    bus_write(4'h0, 32'h0F);
    bus_write(4'h3, 32'h03);
    @(negedge clk);
`ifdef PCIHELLOCORE_PIO_BLINK_EN
    read_chk("bmask_rd", 4'h3, 32'h03);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s[i] = out_port[7:0];
      check($sformatf("blink_val_%0d", i),
            32'(s[i] == 8'h0F || s[i] == 8'h0C), 32'd1);
    end
    f = 0;
    for (int i = 1; i < 20; i++)
      if (f == 0 && s[i] != s[i-1]) f = i;
    check("blink_first_edge", 32'(f >= 1 && f <= 4), 32'd1);
    for (int i = f + 1; i < 20; i++) begin
      chg  = (s[i] != s[i-1]);
      want = ((i - f) % 4 == 0);
      check($sformatf("blink_edge_%0d", i), 32'(chg), 32'(want));
    end
    check("blink_others", 32'(out_port[23:8]), 32'h8355);
    bus_write(4'h3, 32'h00);
    @(negedge clk);
`else
    read_chk("bmask_rd", 4'h3, 32'h00);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("steady_%0d", i), 32'(out_port), 32'h83550F);
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out_port), 32'h050505);
    read_chk("async_rst_rd", 4'h0, 32'h05);
    read_chk("async_rst_bmask", 4'h3, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(24'h770505);
    bus_write(4'h8, 32'h77);
    @(negedge clk);
    pop_chk("post_rst_write");
    read_chk("post_rst_rd", 4'h8, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
